// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared types and constants for the pipeline control slice.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        TIMED_OUT = 2'd2
    } hazard_state_e;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/load_use_detector.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detector
// Description : Flags an ID instruction that reads the destination of a load
//               currently in EX. Writes to $zero never create a dependency.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_write_addr,
    input  logic [4:0] i_id_rs_addr,
    input  logic [4:0] i_id_rt_addr,
    input  logic       i_id_uses_rs,
    input  logic       i_id_uses_rt,
    output logic       o_hazard
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = i_id_uses_rs && (i_id_rs_addr == i_ex_write_addr);
    assign w_rt_match = i_id_uses_rt && (i_id_rt_addr == i_ex_write_addr);
    assign o_hazard   = i_ex_is_load && (i_ex_write_addr != REG_ZERO)
                        && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall/flush sequencer for the 5-stage pipeline with memory-wait
//               freeze, timeout detection and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs_addr,
    input  logic [4:0]           id_rt_addr,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_is_load,
    input  logic [4:0]           ex_write_addr,
    input  logic                 ex_branch_taken,
    input  logic                 mem_access,
    input  logic                 dmem_ready,
    output logic                 pc_write_enable,
    output logic                 ifid_write_enable,
    output logic                 ifid_flush,
    output logic                 idex_write_enable,
    output logic                 idex_flush,
    output logic                 exmem_write_enable,
    output logic                 memwb_bubble,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events,
    output logic                 mem_timeout,
    output logic [1:0]           busy_state
);

    localparam int                  c_WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(TIMEOUT_CYCLES);

    hazard_state_e        r_state;
    hazard_state_e        w_next_state;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic [c_WAIT_W-1:0]  w_wait_inc;
    logic                 w_mem_wait;
    logic                 w_load_use;
    logic                 w_hit_timeout;
    logic                 w_branch;

    load_use_detector u_load_use (
        .i_ex_is_load    (ex_is_load),
        .i_ex_write_addr (ex_write_addr),
        .i_id_rs_addr    (id_rs_addr),
        .i_id_rt_addr    (id_rt_addr),
        .i_id_uses_rs    (id_uses_rs),
        .i_id_uses_rt    (id_uses_rt),
        .o_hazard        (w_load_use)
    );

    assign w_mem_wait    = mem_access && !dmem_ready;
    assign w_branch      = !rst && !w_mem_wait && ex_branch_taken;
    assign w_wait_inc    = r_wait_cnt + 1'b1;
    // Every frozen cycle counts, including the one that first raises the wait.
    assign w_hit_timeout = w_mem_wait && (r_state != TIMED_OUT) && (w_wait_inc == c_TIMEOUT);

    always_comb begin
        pc_write_enable    = 1'b0;
        ifid_write_enable  = 1'b0;
        ifid_flush         = 1'b0;
        idex_write_enable  = 1'b0;
        idex_flush         = 1'b0;
        exmem_write_enable = 1'b0;
        memwb_bubble       = 1'b0;
        w_next_state       = RUN;
        if (!rst) begin
            if (w_mem_wait) begin
                memwb_bubble = 1'b1;
                if (w_hit_timeout || (r_state == TIMED_OUT)) begin
                    w_next_state = TIMED_OUT;
                end else begin
                    w_next_state = MEM_WAIT;
                end
            end else if (ex_branch_taken) begin
                pc_write_enable    = 1'b1;
                ifid_write_enable  = 1'b1;
                ifid_flush         = 1'b1;
                idex_write_enable  = 1'b1;
                idex_flush         = 1'b1;
                exmem_write_enable = 1'b1;
            end else if (w_load_use) begin
                idex_write_enable  = 1'b1;
                idex_flush         = 1'b1;
                exmem_write_enable = 1'b1;
            end else begin
                pc_write_enable    = 1'b1;
                ifid_write_enable  = 1'b1;
                idex_write_enable  = 1'b1;
                exmem_write_enable = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_wait_cnt   <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (!w_mem_wait) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_TIMEOUT) begin
                r_wait_cnt <= w_wait_inc;
            end
            if (w_hit_timeout) begin
                mem_timeout <= 1'b1;
            end
            if (!pc_write_enable) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (w_branch) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

    assign busy_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed self-checking bench for pipeline_hazard_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    // Control vector order: pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble
    localparam logic [6:0] c_CTL_RST    = 7'b0000000;
    localparam logic [6:0] c_CTL_NORMAL = 7'b1101010;
    localparam logic [6:0] c_CTL_LU     = 7'b0001110;
    localparam logic [6:0] c_CTL_BRANCH = 7'b1111110;
    localparam logic [6:0] c_CTL_WAIT   = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs_addr, id_rt_addr, ex_write_addr;
    logic        id_uses_rs, id_uses_rt, ex_is_load, ex_branch_taken;
    logic        mem_access, dmem_ready;
    logic        pc_write_enable, ifid_write_enable, ifid_flush, idex_write_enable;
    logic        idex_flush, exmem_write_enable, memwb_bubble, mem_timeout;
    logic [31:0] stall_cycles, flush_events;
    logic [1:0]  busy_state;
    logic [6:0]  w_ctl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .TIMEOUT_CYCLES (4),
        .CNT_WIDTH      (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .id_rs_addr         (id_rs_addr),
        .id_rt_addr         (id_rt_addr),
        .id_uses_rs         (id_uses_rs),
        .id_uses_rt         (id_uses_rt),
        .ex_is_load         (ex_is_load),
        .ex_write_addr      (ex_write_addr),
        .ex_branch_taken    (ex_branch_taken),
        .mem_access         (mem_access),
        .dmem_ready         (dmem_ready),
        .pc_write_enable    (pc_write_enable),
        .ifid_write_enable  (ifid_write_enable),
        .ifid_flush         (ifid_flush),
        .idex_write_enable  (idex_write_enable),
        .idex_flush         (idex_flush),
        .exmem_write_enable (exmem_write_enable),
        .memwb_bubble       (memwb_bubble),
        .stall_cycles       (stall_cycles),
        .flush_events       (flush_events),
        .mem_timeout        (mem_timeout),
        .busy_state         (busy_state)
    );

    assign w_ctl = {pc_write_enable, ifid_write_enable, ifid_flush, idex_write_enable,
                    idex_flush, exmem_write_enable, memwb_bubble};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; ex_write_addr = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_is_load = 1'b0;
        ex_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] dst, input logic use_rs, input logic use_rt,
                                input logic [4:0] rs, input logic [4:0] rt);
        ex_is_load = 1'b1; ex_write_addr = dst;
        id_uses_rs = use_rs; id_uses_rt = use_rt;
        id_rs_addr = rs;     id_rt_addr = rt;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        check("rst_ctl", 32'(w_ctl), 32'(c_CTL_RST));
        check("rst_state", 32'(busy_state), 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        check("rst_flush", flush_events, 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);

        next_cycle(); rst = 1'b0;
        @(negedge clk);
        check("normal_ctl", 32'(w_ctl), 32'(c_CTL_NORMAL));

        // Load-use on rs
        next_cycle(); set_load_use(5'd8, 1'b1, 1'b0, 5'd8, 5'd3);
        @(negedge clk);
        check("lu_rs_ctl", 32'(w_ctl), 32'(c_CTL_LU));
        check("lu_rs_stall_before", stall_cycles, 32'd0);
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("lu_rs_stall_after", stall_cycles, 32'd1);
        check("lu_release_ctl", 32'(w_ctl), 32'(c_CTL_NORMAL));

        // Load-use on rt; rs matches but is not read
        next_cycle(); set_load_use(5'd9, 1'b0, 1'b1, 5'd9, 5'd9);
        @(negedge clk);
        check("lu_rt_ctl", 32'(w_ctl), 32'(c_CTL_LU));
        next_cycle(); set_load_use(5'd9, 1'b0, 1'b0, 5'd9, 5'd9);
        @(negedge clk);
        check("lu_unused_ctl", 32'(w_ctl), 32'(c_CTL_NORMAL));
        check("lu_rt_stall", stall_cycles, 32'd2);

        // $zero destination never stalls
        next_cycle(); set_load_use(5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
        @(negedge clk);
        check("zero_ctl", 32'(w_ctl), 32'(c_CTL_NORMAL));
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("zero_stall", stall_cycles, 32'd2);

        // Branch overrides load-use
        next_cycle(); set_load_use(5'd8, 1'b1, 1'b0, 5'd8, 5'd0); ex_branch_taken = 1'b1;
        @(negedge clk);
        check("br_ctl", 32'(w_ctl), 32'(c_CTL_BRANCH));
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("br_flush_cnt", flush_events, 32'd1);
        check("br_stall_cnt", stall_cycles, 32'd2);

        // Memory wait of three cycles, branch held in EX acted on at release
        next_cycle(); mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        @(negedge clk);
        check("mw1_ctl", 32'(w_ctl), 32'(c_CTL_WAIT));
        check("mw1_state", 32'(busy_state), 32'd0);
        for (int i = 2; i <= 3; i++) begin
            next_cycle();
            @(negedge clk);
            check("mw_ctl", 32'(w_ctl), 32'(c_CTL_WAIT));
            check("mw_state", 32'(busy_state), 32'd1);
        end
        next_cycle(); dmem_ready = 1'b1;
        @(negedge clk);
        check("mw_release_ctl", 32'(w_ctl), 32'(c_CTL_BRANCH));
        check("mw_release_state", 32'(busy_state), 32'd1);
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("mw_done_state", 32'(busy_state), 32'd0);
        check("mw_stall_cnt", stall_cycles, 32'd5);
        check("mw_flush_cnt", flush_events, 32'd2);

        // Ready in the same cycle as the request: no stall
        next_cycle(); mem_access = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        check("fast_ctl", 32'(w_ctl), 32'(c_CTL_NORMAL));
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("fast_state", 32'(busy_state), 32'd0);
        check("fast_stall", stall_cycles, 32'd5);

        // Timeout after the fourth wait cycle
        for (int i = 1; i <= 6; i++) begin
            next_cycle(); mem_access = 1'b1; dmem_ready = 1'b0;
            @(negedge clk);
            check("to_ctl", 32'(w_ctl), 32'(c_CTL_WAIT));
            if (i == 4) begin
                check("to_state_w4", 32'(busy_state), 32'd1);
                check("to_flag_w4", 32'(mem_timeout), 32'd0);
            end
            if (i == 5) begin
                check("to_state_w5", 32'(busy_state), 32'd2);
                check("to_flag_w5", 32'(mem_timeout), 32'd1);
            end
        end
        next_cycle(); dmem_ready = 1'b1;
        @(negedge clk);
        check("to_release_ctl", 32'(w_ctl), 32'(c_CTL_NORMAL));
        check("to_release_state", 32'(busy_state), 32'd2);
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("to_done_state", 32'(busy_state), 32'd0);
        check("to_sticky", 32'(mem_timeout), 32'd1);
        check("to_stall_cnt", stall_cycles, 32'd11);

        // Reset in the middle of a wait
        next_cycle(); mem_access = 1'b1; dmem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rw_state", 32'(busy_state), 32'd1);
        next_cycle(); rst = 1'b1;
        @(negedge clk);
        check("rw_rst_ctl", 32'(w_ctl), 32'(c_CTL_RST));
        next_cycle();
        @(negedge clk);
        check("rw_state_after", 32'(busy_state), 32'd0);
        check("rw_stall", stall_cycles, 32'd0);
        check("rw_flush", flush_events, 32'd0);
        check("rw_timeout", 32'(mem_timeout), 32'd0);
        check("rw_ctl_held", 32'(w_ctl), 32'(c_CTL_RST));
        next_cycle(); rst = 1'b0; clear_inputs();
        @(negedge clk);
        check("post_rst_ctl", 32'(w_ctl), 32'(c_CTL_NORMAL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
